// File: rtl/alu_writeback.sv
// alu_writeback: pairs ALU results with in-order destination tags and writes
// them into an 8-entry register file, with a one-cycle completion pulse.
module alu_writeback #(
    parameter int DATA_W    = 32,
    parameter int TAG_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [2:0]        issue_dest,
    output logic              issue_ready,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              res_ready,
    input  logic [2:0]        rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    input  logic [2:0]        rd_addr2,
    output logic [DATA_W-1:0] rd_data2,
    output logic              wb_done,
    output logic [2:0]        wb_addr,
    output logic              busy,
    output logic              err_orphan
);

    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W = $clog2(TAG_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TAG_DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] regs [8];
    logic [2:0]        tags [TAG_DEPTH];
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q;
    logic              push, pop;
    logic [2:0]        head_tag;

    // Handshakes: both flags come from registered count only, so a pop
    // never frees a slot for a push in the same cycle and a fresh tag
    // never falls through to a same-cycle result.
    assign issue_ready = (count_q != FULL_CNT);
    assign res_ready   = (count_q != '0);
    assign push        = issue_valid && issue_ready;
    assign pop         = res_valid && res_ready;
    assign head_tag    = tags[head_q];
    assign busy        = (state_q == PENDING);

    // Combinational register-file reads: a write shows up the cycle after.
    assign rd_data1 = regs[rd_addr1];
    assign rd_data2 = regs[rd_addr2];

    // Tag storage; only entries between head and tail are ever read.
    // NOTE: the tag array has no reset because the pointers and count fully
    // qualify it, whereas the register file must read back 0 after reset.
    always_ff @(posedge clk) begin
        if (push) begin
            tags[tail_q] <= issue_dest;
        end
    end

    // Register file write on each accepted result.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (pop) begin
            regs[head_tag] <= res_data;
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + PTR_W'(1);
            if (pop)  head_q <= head_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + ONE_CNT;
                2'b01:   count_q <= count_q - ONE_CNT;
                default: count_q <= count_q;
            endcase
        end
    end

    // Completion pulse, last written address and sticky orphan flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_done    <= 1'b0;
            wb_addr    <= '0;
            err_orphan <= 1'b0;
        end else begin
            wb_done <= pop;
            if (pop) wb_addr <= head_tag;
            if (res_valid && !res_ready) err_orphan <= 1'b1;
        end
    end

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: PENDING whenever at least one tag is outstanding.
    // NOTE: state_d is assigned a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (push && !pop) state_d = PENDING;
            end
            PENDING: begin
                if (pop && !push && count_q == ONE_CNT) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback with a tag model and write-back scoreboard.
module tb_alu_writeback;

    localparam int DATA_W    = 32;
    localparam int TAG_DEPTH = 4;

    typedef struct {
        logic [2:0]        addr;
        logic [DATA_W-1:0] data;
    } wb_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              issue_valid = 1'b0;
    logic [2:0]        issue_dest = '0;
    logic              issue_ready;
    logic              res_valid = 1'b0;
    logic [DATA_W-1:0] res_data = '0;
    logic              res_ready;
    logic [2:0]        rd_addr1 = '0;
    logic [DATA_W-1:0] rd_data1;
    logic [2:0]        rd_addr2 = '0;
    logic [DATA_W-1:0] rd_data2;
    logic              wb_done;
    logic [2:0]        wb_addr;
    logic              busy;
    logic              err_orphan;

    int checks = 0;
    int errors = 0;

    logic [2:0]        model_q [$];
    wb_t               sb [$];
    logic [DATA_W-1:0] model_regs [8];
    logic              exp_orphan = 1'b0;
    logic [2:0]        exp_wb_addr = '0;

    alu_writeback #(.DATA_W(DATA_W), .TAG_DEPTH(TAG_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_ready(issue_ready),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .rd_addr1(rd_addr1), .rd_data1(rd_data1),
        .rd_addr2(rd_addr2), .rd_data2(rd_data2),
        .wb_done(wb_done), .wb_addr(wb_addr),
        .busy(busy), .err_orphan(err_orphan)
    );

    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag);
        int n;
        n = model_q.size();
        check({tag, ".issue_ready"}, 64'(issue_ready), 64'(n != TAG_DEPTH));
        check({tag, ".res_ready"},   64'(res_ready),   64'(n != 0));
        check({tag, ".busy"},        64'(busy),        64'(n != 0));
        check({tag, ".err_orphan"},  64'(err_orphan),  64'(exp_orphan));
        check({tag, ".wb_addr"},     64'(wb_addr),     64'(exp_wb_addr));
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            rd_addr1 = 3'(i);
            #1;
            check($sformatf("%s.reg%0d", tag, i), 64'(rd_data1), 64'(model_regs[i]));
        end
    endtask

    // Apply the currently driven inputs for one clock edge, updating the model
    // beforehand and checking outputs 1ns after the edge.
    task automatic tick(input string tag);
        logic push, pop;
        logic [2:0] t;
        wb_t e;
        push = issue_valid && (model_q.size() < TAG_DEPTH);
        pop  = res_valid && (model_q.size() > 0);
        if (res_valid && model_q.size() == 0) exp_orphan = 1'b1;
        if (pop) begin
            t = model_q.pop_front();
            sb.push_back('{addr: t, data: res_data});
        end
        if (push) model_q.push_back(issue_dest);
        @(posedge clk);
        #1;
        check({tag, ".wb_done"}, 64'(wb_done), 64'(pop));
        if (wb_done && sb.size() > 0) begin
            e = sb.pop_front();
            model_regs[e.addr] = e.data;
            exp_wb_addr = e.addr;
            rd_addr2 = e.addr;
            #1;
            check({tag, ".wb_reg"}, 64'(rd_data2), 64'(e.data));
        end
        check_status(tag);
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        res_valid   = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) model_regs[i] = '0;

        // Reset state
        #12;
        check_status("reset");
        check("reset.wb_done", 64'(wb_done), 64'(0));
        check_regs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Basic: issue 5 on the first edge after reset, then result
        issue_valid = 1'b1; issue_dest = 3'd5;
        tick("basic_issue");
        idle();
        res_valid = 1'b1; res_data = 32'hDEAD_BEEF;
        tick("basic_res");
        idle();
        rd_addr1 = 3'd5; #1;
        check("basic.rd5", 64'(rd_data1), 64'(32'hDEAD_BEEF));
        tick("basic_after");

        // Ordering / full, including an ignored push while full
        for (int i = 1; i <= 4; i++) begin
            issue_valid = 1'b1; issue_dest = 3'(i);
            tick($sformatf("fill%0d", i));
        end
        issue_dest = 3'd7;
        tick("push_full");
        idle();
        for (int i = 1; i <= 4; i++) begin
            res_valid = 1'b1; res_data = 32'(i * 'h11);
            tick($sformatf("drain%0d", i));
        end
        idle();
        tick("drain_end");
        check_regs("order");

        // Simultaneous push and pop with count 2
        issue_valid = 1'b1; issue_dest = 3'd6; tick("sim_i6");
        issue_dest = 3'd7; tick("sim_i7");
        issue_dest = 3'd0; res_valid = 1'b1; res_data = 32'hAA; tick("sim_both");
        idle();
        res_valid = 1'b1; res_data = 32'hBB; tick("sim_r7");
        res_data = 32'hCC; tick("sim_r0");
        idle();
        tick("sim_end");
        check_regs("sim");

        // Read timing: old value in write cycle, new value after
        issue_valid = 1'b1; issue_dest = 3'd3; tick("rt_i1");
        issue_valid = 1'b0; res_valid = 1'b1; res_data = 32'h10; tick("rt_r1");
        issue_valid = 1'b1; res_valid = 1'b0; tick("rt_i2");
        issue_valid = 1'b0; res_valid = 1'b1; res_data = 32'h20;
        rd_addr1 = 3'd3; #1;
        check("rt.write_cycle", 64'(rd_data1), 64'(32'h10));
        tick("rt_r2");
        idle();
        check("rt.next_cycle", 64'(rd_data1), 64'(32'h20));

        // Orphan result: dropped, sticky error
        res_valid = 1'b1; res_data = 32'h55; tick("orphan");
        idle();
        tick("orphan_hold1");
        tick("orphan_hold2");
        check_regs("orphan");

        // Reset mid-operation: 3 tags pending, result offered as rst rises
        for (int i = 0; i < 3; i++) begin
            issue_valid = 1'b1; issue_dest = 3'(i + 2);
            tick($sformatf("rm_i%0d", i));
        end
        idle();
        res_valid = 1'b1; res_data = 32'h99;
        #5 rst = 1'b1;
        model_q.delete();
        sb.delete();
        for (int i = 0; i < 8; i++) model_regs[i] = '0;
        exp_orphan = 1'b0;
        exp_wb_addr = '0;
        #1;
        check_status("rm_async");
        @(posedge clk); #1;
        check("rm.wb_done", 64'(wb_done), 64'(0));
        check_status("rm_edge");
        check_regs("rm");
        idle();
        @(negedge clk);
        rst = 1'b0;
        tick("rm_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
